// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-port driver.
package wb_pkg;

    localparam int             NREG     = 32;
    localparam int             REG_W    = 5;
    localparam int             DATA_W   = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // One pending register-file write: destination and value.
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Slow-path result buffer: DEPTH-entry circular FIFO of wb_req_t.
// Push is ignored when full and pop is ignored when empty.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    wb_req_t       mem_q [DEPTH];
    wb_req_t       mem_d [DEPTH];
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrap modulo DEPTH) and occupancy.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_req;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards all buffered entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/wb_port.sv
// Register-file write-port driver: merges the ALU result path and the
// buffered slow (load/mul/div) path onto one registered write port,
// with starvation-bounded arbitration and a pending-destination scoreboard.
module wb_port
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int STARVE = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  q_ra,
    input  logic [4:0]  q_rb,
    output logic        q_busy,
    output logic        RegWrite,
    output logic [4:0]  rc,
    output logic [31:0] dc
);

    localparam int SW = $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    wb_req_t fifo_head, mem_req;
    logic    fifo_full, fifo_empty;
    logic    force_fifo, grant_fifo, grant_alu;

    logic [SW-1:0]     starve_q, starve_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic              regwrite_q, regwrite_d;
    logic [REG_W-1:0]  rc_q, rc_d;
    logic [DATA_W-1:0] dc_q, dc_d;

    assign mem_req = '{rd: mem_rd, data: mem_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (mem_valid),
        .push_req (mem_req),
        .pop      (grant_fifo),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Arbitration: ALU by default, FIFO when ALU idle or after STARVE losses.
    always_comb begin
        force_fifo = ~fifo_empty & (starve_q == STARVE_MAX);
        grant_fifo = ~fifo_empty & (~alu_valid | force_fifo);
        grant_alu  = alu_valid & ~force_fifo;
    end

    assign alu_ready = ~force_fifo;
    assign mem_ready = ~fifo_full;
    assign q_busy    = pend_q[q_ra] | pend_q[q_rb];
    assign RegWrite  = regwrite_q;
    assign rc        = rc_q;
    assign dc        = dc_q;

    // Starve counter, scoreboard and write-port next state.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || grant_fifo) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end

        // Clear on the slow-path grant first so a same-cycle issue wins.
        pend_d = pend_q;
        if (grant_fifo) pend_d[fifo_head.rd] = 1'b0;
        if (iss_valid)  pend_d[iss_rd]       = 1'b1;
        pend_d[REG_ZERO] = 1'b0;

        // rd=0 grants are consumed but never strobe the register file.
        regwrite_d = 1'b0;
        rc_d       = rc_q;
        dc_d       = dc_q;
        if (grant_fifo) begin
            regwrite_d = (fifo_head.rd != REG_ZERO);
            rc_d       = fifo_head.rd;
            dc_d       = fifo_head.data;
        end else if (grant_alu) begin
            regwrite_d = (alu_rd != REG_ZERO);
            rc_d       = alu_rd;
            dc_d       = alu_data;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q   <= '0;
            pend_q     <= '0;
            regwrite_q <= 1'b0;
            rc_q       <= '0;
            dc_q       <= '0;
        end else begin
            starve_q   <= starve_d;
            pend_q     <= pend_d;
            regwrite_q <= regwrite_d;
            rc_q       <= rc_d;
            dc_q       <= dc_d;
        end
    end

endmodule

// File: tb/tb_wb_port.sv
// Directed self-checking bench for wb_port (DEPTH=4, STARVE=3).
module tb_wb_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        iss_valid;
    logic [4:0]  iss_rd, q_ra, q_rb;
    logic        q_busy, RegWrite;
    logic [4:0]  rc;
    logic [31:0] dc;

    int nchecks = 0;
    int nerrors = 0;

    wb_port #(.DEPTH(4), .STARVE(3)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .q_ra(q_ra), .q_rb(q_rb), .q_busy(q_busy),
        .RegWrite(RegWrite), .rc(rc), .dc(dc)
    );

    always #5 clk = ~clk;

    // Advance past an edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        iss_valid = 0; iss_rd = 0; q_ra = 0; q_rb = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        tick(); tick();
        reset = 0; q_ra = 5; q_rb = 6;
        #1;
        nchecks++; if (RegWrite !== 1'b0) begin nerrors++; $display("FAIL rst_we got %0b want 0", RegWrite); end
        nchecks++; if (rc !== 5'd0) begin nerrors++; $display("FAIL rst_rc got %0d want 0", rc); end
        nchecks++; if (dc !== 32'd0) begin nerrors++; $display("FAIL rst_dc got %h want 0", dc); end
        nchecks++; if (mem_ready !== 1'b1) begin nerrors++; $display("FAIL rst_mem_ready got %0b want 1", mem_ready); end
        nchecks++; if (alu_ready !== 1'b1) begin nerrors++; $display("FAIL rst_alu_ready got %0b want 1", alu_ready); end
        nchecks++; if (q_busy !== 1'b0) begin nerrors++; $display("FAIL rst_q_busy got %0b want 0", q_busy); end
    endtask

    task automatic test_alu();
        alu_valid = 1; alu_rd = 8; alu_data = 32'h5; q_ra = 8; q_rb = 8;
        #1;
        nchecks++; if (alu_ready !== 1'b1) begin nerrors++; $display("FAIL alu_ready got %0b want 1", alu_ready); end
        tick();
        alu_valid = 0;
        #1;
        nchecks++; if (RegWrite !== 1'b1 || rc !== 5'd8 || dc !== 32'h5)
            begin nerrors++; $display("FAIL alu_write got we=%0b rc=%0d dc=%h want 1/8/5", RegWrite, rc, dc); end
        nchecks++; if (q_busy !== 1'b0) begin nerrors++; $display("FAIL alu_q_busy got %0b want 0", q_busy); end
        tick();
        nchecks++; if (RegWrite !== 1'b0) begin nerrors++; $display("FAIL alu_we_once got %0b want 0", RegWrite); end
    endtask

    task automatic test_slow_path();
        iss_valid = 1; iss_rd = 9; q_ra = 9; q_rb = 0;
        tick();
        iss_valid = 0;
        #1;
        nchecks++; if (q_busy !== 1'b1) begin nerrors++; $display("FAIL slow_busy1 got %0b want 1", q_busy); end
        tick();
        mem_valid = 1; mem_rd = 9; mem_data = 32'hDEAD_BEEF;
        #1;
        nchecks++; if (q_busy !== 1'b1) begin nerrors++; $display("FAIL slow_busy2 got %0b want 1", q_busy); end
        tick();  // push edge
        mem_valid = 0;
        #1;
        nchecks++; if (q_busy !== 1'b1 || RegWrite !== 1'b0)
            begin nerrors++; $display("FAIL slow_grant_cycle got busy=%0b we=%0b want 1/0", q_busy, RegWrite); end
        tick();  // grant captured
        nchecks++; if (RegWrite !== 1'b1 || rc !== 5'd9 || dc !== 32'hDEAD_BEEF)
            begin nerrors++; $display("FAIL slow_write got we=%0b rc=%0d dc=%h want 1/9/deadbeef", RegWrite, rc, dc); end
        nchecks++; if (q_busy !== 1'b0) begin nerrors++; $display("FAIL slow_free got %0b want 0", q_busy); end
        tick();
        nchecks++; if (RegWrite !== 1'b0 || q_busy !== 1'b0)
            begin nerrors++; $display("FAIL slow_after got we=%0b busy=%0b want 0/0", RegWrite, q_busy); end
    endtask

    // ALU held busy; one slow entry must get through after three losses.
    task automatic test_starve();
        alu_valid = 1; alu_rd = 1; alu_data = 100;
        mem_valid = 1; mem_rd = 10; mem_data = 32'hA;
        tick();
        mem_valid = 0;
        nchecks++; if (RegWrite !== 1'b1 || rc !== 5'd1 || dc !== 32'd100)
            begin nerrors++; $display("FAIL starve_w0 got we=%0b rc=%0d dc=%0d want 1/1/100", RegWrite, rc, dc); end
        for (int i = 1; i <= 3; i++) begin
            alu_data = 100 + i;
            #1;
            nchecks++; if (alu_ready !== 1'b1) begin nerrors++; $display("FAIL starve_ready%0d got %0b want 1", i, alu_ready); end
            tick();
            nchecks++; if (RegWrite !== 1'b1 || rc !== 5'd1 || dc !== 32'(100 + i))
                begin nerrors++; $display("FAIL starve_alu%0d got we=%0b rc=%0d dc=%0d want 1/1/%0d", i, RegWrite, rc, dc, 100 + i); end
        end
        alu_data = 200;
        #1;
        nchecks++; if (alu_ready !== 1'b0) begin nerrors++; $display("FAIL starve_forced got %0b want 0", alu_ready); end
        tick();
        nchecks++; if (RegWrite !== 1'b1 || rc !== 5'd10 || dc !== 32'hA)
            begin nerrors++; $display("FAIL starve_fifo got we=%0b rc=%0d dc=%h want 1/10/a", RegWrite, rc, dc); end
        nchecks++; if (alu_ready !== 1'b1) begin nerrors++; $display("FAIL starve_resume got %0b want 1", alu_ready); end
        tick();
        alu_valid = 0;
        nchecks++; if (RegWrite !== 1'b1 || rc !== 5'd1 || dc !== 32'd200)
            begin nerrors++; $display("FAIL starve_held got we=%0b rc=%0d dc=%0d want 1/1/200", RegWrite, rc, dc); end
        tick();
        nchecks++; if (RegWrite !== 1'b0) begin nerrors++; $display("FAIL starve_idle got %0b want 0", RegWrite); end
    endtask

    // Fill the FIFO under ALU saturation, then drain in order.
    task automatic test_full();
        logic [4:0] exp_rd;
        alu_valid = 1; alu_rd = 1; alu_data = 7;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1; mem_rd = 5'(20 + i); mem_data = 32'h1000 + 32'(20 + i);
            #1;
            nchecks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1)
                begin nerrors++; $display("FAIL full_push%0d got mr=%0b ar=%0b want 1/1", i, mem_ready, alu_ready); end
            tick();
        end
        mem_rd = 24; mem_data = 32'h1000 + 32'd24;
        #1;
        nchecks++; if (mem_ready !== 1'b0) begin nerrors++; $display("FAIL full_ready got %0b want 0", mem_ready); end
        nchecks++; if (alu_ready !== 1'b0) begin nerrors++; $display("FAIL full_forced got %0b want 0", alu_ready); end
        tick();  // forced pop of 20; 5th offer refused
        nchecks++; if (RegWrite !== 1'b1 || rc !== 5'd20 || dc !== 32'h1014)
            begin nerrors++; $display("FAIL full_pop20 got we=%0b rc=%0d dc=%h want 1/20/1014", RegWrite, rc, dc); end
        nchecks++; if (mem_ready !== 1'b1) begin nerrors++; $display("FAIL full_reopen got %0b want 1", mem_ready); end
        tick();  // 5th pushed, ALU granted
        mem_valid = 0; alu_valid = 0;
        nchecks++; if (RegWrite !== 1'b1 || rc !== 5'd1) begin nerrors++; $display("FAIL full_alu got we=%0b rc=%0d want 1/1", RegWrite, rc); end
        for (int i = 21; i <= 24; i++) begin
            tick();
            exp_rd = 5'(i);
            nchecks++; if (RegWrite !== 1'b1 || rc !== exp_rd || dc !== 32'h1000 + 32'(i))
                begin nerrors++; $display("FAIL full_drain%0d got we=%0b rc=%0d dc=%h", i, RegWrite, rc, dc); end
        end
        tick();
        nchecks++; if (RegWrite !== 1'b0 || mem_ready !== 1'b1)
            begin nerrors++; $display("FAIL full_empty got we=%0b mr=%0b want 0/1", RegWrite, mem_ready); end
    endtask

    task automatic test_rd_zero();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        tick();
        alu_valid = 0;
        nchecks++; if (RegWrite !== 1'b0) begin nerrors++; $display("FAIL rd0_alu got %0b want 0", RegWrite); end
        mem_valid = 1; mem_rd = 0; mem_data = 32'h66;
        tick();
        mem_valid = 0;
        nchecks++; if (dut.u_fifo.count_q !== 3'd1) begin nerrors++; $display("FAIL rd0_push got %0d want 1", dut.u_fifo.count_q); end
        tick();
        nchecks++; if (dut.u_fifo.count_q !== 3'd0) begin nerrors++; $display("FAIL rd0_pop got %0d want 0", dut.u_fifo.count_q); end
        nchecks++; if (RegWrite !== 1'b0) begin nerrors++; $display("FAIL rd0_slow got %0b want 0", RegWrite); end
        iss_valid = 1; iss_rd = 0; q_ra = 0; q_rb = 0;
        tick();
        iss_valid = 0;
        nchecks++; if (q_busy !== 1'b0) begin nerrors++; $display("FAIL rd0_busy got %0b want 0", q_busy); end
    endtask

    task automatic test_reset_mid();
        iss_valid = 1; iss_rd = 11; tick();
        iss_rd = 12; tick();
        iss_valid = 0; q_ra = 11; q_rb = 12;
        #1;
        nchecks++; if (q_busy !== 1'b1) begin nerrors++; $display("FAIL mid_busy got %0b want 1", q_busy); end
        alu_valid = 1; alu_rd = 2; alu_data = 9;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1; mem_rd = 5'(11 + i); mem_data = 32'hBAD0 + 32'(i);
            tick();
        end
        mem_valid = 0; alu_valid = 0; reset = 1;
        tick();
        reset = 0;
        #1;
        nchecks++; if (RegWrite !== 1'b0 || mem_ready !== 1'b1 || q_busy !== 1'b0)
            begin nerrors++; $display("FAIL mid_rst got we=%0b mr=%0b busy=%0b want 0/1/0", RegWrite, mem_ready, q_busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            nchecks++; if (RegWrite !== 1'b0) begin nerrors++; $display("FAIL mid_stale%0d got %0b want 0", i, RegWrite); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_slow_path();
        test_starve();
        test_full();
        test_rd_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
